io_port_ctrl: RTL

- Board-side responder for the CPU's I/O path.
- Synchronises and debounces the confirm button, and latches the 8-bit switch data and 3-bit test index on each accepted press.
- Presents data, index and a sticky confirm flag to the memory/IO bridge.
- Accepts CPU I/O writes, selected by the a7 service code, that load, enable and disable the LED bank.

---
 rtl/io_pkg.sv | 22 ++
 rtl/io_debounce.sv | 78 +++++++
 rtl/io_port_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared constants and types for the board-side I/O responder.
package io_pkg;

  localparam int unsigned SEL_CONFIRM = 0;
  localparam int unsigned SEL_DATA_S  = 1;
  localparam int unsigned SEL_INDEX   = 2;
  localparam int unsigned SEL_DATA_U  = 3;
  localparam int unsigned SEL_LED_ON  = 4;
  localparam int unsigned SEL_LED_OFF = 5;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 200000;
  localparam int unsigned CNT_W_DEF           = 18;
  localparam int unsigned LED_W_DEF           = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HELD = 2'd2,
    ST_REL  = 2'd3
  } db_state_e;

endpackage

// File: rtl/io_debounce.sv
// Confirm-button synchroniser and debounce FSM; pulses press_accept_c once per
// accepted press.
module io_debounce
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_accept_c,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_meta_q, btn_s_q;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;

  // Saturating increment; "hit" means this cycle completes the stable window.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign hit     = (cnt_inc == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_meta_q <= btn_raw;
      btn_s_q    <= btn_meta_q;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (btn_s_q) state_d = ST_ARM;
      ST_ARM: begin
        if (!btn_s_q)  state_d = ST_IDLE;
        else if (hit)  state_d = ST_HELD;
      end
      ST_HELD: if (!btn_s_q) state_d = ST_REL;
      ST_REL: begin
        if (btn_s_q)   state_d = ST_HELD;
        else if (hit)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d          = '0;
    press_accept_c = 1'b0;
    busy_d         = (state_d != ST_IDLE);
    case (state_q)
      ST_ARM: begin
        if (btn_s_q && !hit) cnt_d = cnt_inc;
        press_accept_c = btn_s_q && hit;
      end
      ST_REL: if (!btn_s_q && !hit) cnt_d = cnt_inc;
      default: cnt_d = '0;
    endcase
  end

  assign busy = busy_q;

endmodule

// File: rtl/io_port_ctrl.sv
// Board-side I/O responder: switch capture on debounced confirm press,
// read-to-clear confirm flag, and CPU-controlled LED bank.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned LED_W           = LED_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_confirm,
  input  logic [7:0]       sw_data,
  input  logic [2:0]       sw_index,
  input  logic             io_read,
  input  logic             io_write,
  input  logic [31:0]      sel,
  input  logic [31:0]      wdata,
  output logic [7:0]       io_rdata,
  output logic             confirm_flag,
  output logic [2:0]       test_index,
  output logic [LED_W-1:0] led,
  output logic             busy
);

  logic             press_accept_c;
  logic [7:0]       sw_meta_q, sw_s_q;
  logic [2:0]       idx_meta_q, idx_s_q;
  logic [7:0]       io_rdata_q, io_rdata_d;
  logic [2:0]       test_index_q, test_index_d;
  logic             confirm_q, confirm_d;
  logic [LED_W-1:0] led_reg_q, led_reg_d;
  logic             led_en_q, led_en_d;
  logic [LED_W-1:0] led_q, led_d;

  io_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_confirm),
    .press_accept_c(press_accept_c),
    .busy          (busy)
  );

  generate
    if (LED_W < 32) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^wdata[31:LED_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q    <= '0;
      sw_s_q       <= '0;
      idx_meta_q   <= '0;
      idx_s_q      <= '0;
      io_rdata_q   <= '0;
      test_index_q <= '0;
      confirm_q    <= 1'b0;
      led_reg_q    <= '0;
      led_en_q     <= 1'b0;
      led_q        <= '0;
    end else begin
      sw_meta_q    <= sw_data;
      sw_s_q       <= sw_meta_q;
      idx_meta_q   <= sw_index;
      idx_s_q      <= idx_meta_q;
      io_rdata_q   <= io_rdata_d;
      test_index_q <= test_index_d;
      confirm_q    <= confirm_d;
      led_reg_q    <= led_reg_d;
      led_en_q     <= led_en_d;
      led_q        <= led_d;
    end
  end

  // Capture wins over a same-cycle clearing read so a new press is never lost.
  always_comb begin
    io_rdata_d   = io_rdata_q;
    test_index_d = test_index_q;
    confirm_d    = confirm_q;
    if (press_accept_c) begin
      io_rdata_d   = sw_s_q;
      test_index_d = idx_s_q;
      confirm_d    = 1'b1;
    end else if (io_read && (sel == 32'(SEL_CONFIRM))) begin
      confirm_d    = 1'b0;
    end
  end

  always_comb begin
    led_reg_d = led_reg_q;
    led_en_d  = led_en_q;
    if (io_write && (sel == 32'(SEL_LED_ON))) begin
      led_reg_d = wdata[LED_W-1:0];
      led_en_d  = 1'b1;
    end else if (io_write && (sel == 32'(SEL_LED_OFF))) begin
      led_en_d  = 1'b0;
    end
    led_d = led_en_q ? led_reg_q : '0;
  end

  assign io_rdata     = io_rdata_q;
  assign test_index   = test_index_q;
  assign confirm_flag = confirm_q;
  assign led          = led_q;

endmodule
